pci_emu_initiator: RTL and testbench

//  PCI bus initiator emulator: drives the simplified emulated-PCI transaction (address/command phase,

---
 rtl/pci_emu_initiator_if.sv | 35 +++
 rtl/pci_emu_initiator.sv | 145 ++++++++++++++
 tb/tb_pci_emu_initiator.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pci_emu_initiator_if.sv
// Host command/response port and PCI control outputs of the emulated-PCI initiator.
//   CMD_*      host -> initiator command (valid/ready)
//   RSP_*      one-clock completion strobe, error flag, captured read data
//   BUSY       initiator not idle
//   PCI_CBE    command/byte-enable lines
//   PCI_FRAME  active-low transaction frame
//   PCI_DEVSEL active-low data-phase select
// The muxed PCI_AD bus is a tristate net and is carried as a plain inout port
// on the initiator, not through this interface.
interface pci_emu_initiator_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [3:0]  CMD_OP;
  logic [31:0] CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic        RSP_ERR;
  logic [31:0] RSP_RDATA;
  logic        BUSY;
  logic [3:0]  PCI_CBE;
  logic        PCI_FRAME;
  logic        PCI_DEVSEL;

  modport master (
    input  CMD_VALID, CMD_OP, CMD_ADDR, CMD_WDATA,
    output CMD_READY, RSP_VALID, RSP_ERR, RSP_RDATA, BUSY,
           PCI_CBE, PCI_FRAME, PCI_DEVSEL
  );

  modport slave (
    output CMD_VALID, CMD_OP, CMD_ADDR, CMD_WDATA,
    input  CMD_READY, RSP_VALID, RSP_ERR, RSP_RDATA, BUSY,
           PCI_CBE, PCI_FRAME, PCI_DEVSEL
  );
endinterface

// File: rtl/pci_emu_initiator.sv
// Emulated-PCI bus initiator. Accepts one host command at a time, runs a
// single address/data transaction (no bursts, no parity) and returns status
// and read data on a one-clock response strobe.
// Ports:
//   PCI_CLK2  sole clock, all state changes on posedge
//   PCI_RST   asynchronous active-low reset
//   bus       host command/response + PCI control outputs (master modport)
//   PCI_AD    muxed address/data, driven only in ADDR and write DATA
// Parameter DATA_CYCLES (1..16): data-phase length; read data is sampled at
// the posedge that ends the last data clock.
module pci_emu_initiator #(
  parameter int DATA_CYCLES = 1
) (
  input  logic                PCI_CLK2,
  input  logic                PCI_RST,
  pci_emu_initiator_if.master bus,
  inout  wire  [31:0]         PCI_AD
);

  generate
    if (DATA_CYCLES < 1 || DATA_CYCLES > 16) begin : g_bad_cfg
      $error("pci_emu_initiator: DATA_CYCLES must be in 1..16");
    end
  endgenerate

  localparam logic [3:0] LAST_CNT = 4'(DATA_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_ADDR, S_TURN, S_DATA, S_RECOVER
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h2) || (op == 4'h4) || (op == 4'h8);
  endfunction

  function automatic logic op_read(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h4);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        frame_q, frame_d;
  logic        devsel_q, devsel_d;
  logic [3:0]  cbe_q, cbe_d;
  logic        ad_oe_q, ad_oe_d;
  logic [31:0] ad_q, ad_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        in_frame;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.CMD_VALID) begin
          op_d    = bus.CMD_OP;
          addr_d  = bus.CMD_ADDR;
          wdata_d = bus.CMD_WDATA;
          state_d = op_legal(bus.CMD_OP) ? S_ADDR : S_ERR;
        end
      end
      S_ERR:  state_d = S_IDLE;
      S_ADDR: begin
        cnt_d   = '0;
        // Reads need a turnaround clock so the target's combinational AD
        // drive never meets ours.
        state_d = op_read(op_q) ? S_TURN : S_DATA;
      end
      S_TURN: state_d = S_DATA;
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_RECOVER;
          if (op_read(op_q)) rdata_d = PCI_AD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Bus outputs are decoded from the next state so they land in flops and
    // change exactly with the state register.
    in_frame    = (state_d == S_ADDR) || (state_d == S_TURN) || (state_d == S_DATA);
    frame_d     = !in_frame;
    devsel_d    = (state_d != S_DATA);
    cbe_d       = in_frame ? op_d : 4'hF;
    ad_oe_d     = (state_d == S_ADDR) || ((state_d == S_DATA) && !op_read(op_d));
    ad_d        = (state_d == S_ADDR) ? addr_d : wdata_d;
    rsp_valid_d = (state_d == S_ERR) || (state_d == S_RECOVER);
    rsp_err_d   = (state_d == S_ERR);
  end

  always_ff @(posedge PCI_CLK2 or negedge PCI_RST) begin
    if (!PCI_RST) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      frame_q     <= 1'b1;
      devsel_q    <= 1'b1;
      cbe_q       <= 4'hF;
      ad_oe_q     <= 1'b0;
      ad_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      frame_q     <= frame_d;
      devsel_q    <= devsel_d;
      cbe_q       <= cbe_d;
      ad_oe_q     <= ad_oe_d;
      ad_q        <= ad_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PCI_AD         = ad_oe_q ? ad_q : 'z;
  assign bus.CMD_READY  = (state_q == S_IDLE);
  assign bus.BUSY       = (state_q != S_IDLE);
  assign bus.RSP_VALID  = rsp_valid_q;
  assign bus.RSP_ERR    = rsp_err_q;
  assign bus.RSP_RDATA  = rdata_q;
  assign bus.PCI_CBE    = cbe_q;
  assign bus.PCI_FRAME  = frame_q;
  assign bus.PCI_DEVSEL = devsel_q;

endmodule

// File: tb/tb_pci_emu_initiator.sv
// Bench for pci_emu_initiator: a small PCI target model on the bus side
// (memory with a 9-bit GPIO loopback at mod address 0x04), a bus-rule
// monitor, and a transaction-level reference model for responses/latency.
module tb_pci_emu_initiator;
  localparam int DC = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  wire  [31:0] pci_ad;
  logic        tgt_oe;
  logic [31:0] tgt_dat;

  int total = 0;
  int bad   = 0;
  int rsp_cnt = 0, frame_low_cnt = 0, we_cnt = 0, wd_viol = 0, ovl_viol = 0;
  int hi_run = 0;
  logic in_fr = 1'b0, first_d = 1'b0, seen_fr = 1'b0;
  logic [31:0] wd_ref = '0;
  logic [31:0] taddr = '0;
  logic [3:0]  tcmd  = 4'hF;
  logic [31:0] tmem [128];
  logic [31:0] ref_mem [logic [32:0]];
  logic [31:0] ref_rdata = '0;

  pci_emu_initiator_if bus();

  pci_emu_initiator #(.DATA_CYCLES(DC)) dut (
    .PCI_CLK2 (clk),
    .PCI_RST  (rst_n),
    .bus      (bus),
    .PCI_AD   (pci_ad)
  );

  always #5 clk = ~clk;

  assign pci_ad = tgt_oe ? tgt_dat : 'z;

  // Target read drive: combinational from DEVSEL and the latched address.
  always_comb begin
    tgt_oe  = rst_n && !bus.PCI_DEVSEL && (bus.PCI_CBE == 4'h1 || bus.PCI_CBE == 4'h4);
    tgt_dat = tmem[{bus.PCI_CBE == 4'h4, taddr[7:2]}];
    if (bus.PCI_CBE == 4'h1 && taddr[7:2] == 6'd1) tgt_dat = tgt_dat & 32'h1FF;
  end

  // Target sampling and bus-rule monitor, on negedge.
  initial begin
    for (int i = 0; i < 128; i++) tmem[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_fr = 1'b0; seen_fr = 1'b0; hi_run = 0;
      end else begin
        if (bus.RSP_VALID) rsp_cnt++;
        if (!bus.PCI_FRAME) begin
          frame_low_cnt++;
          if (!in_fr) begin
            taddr = pci_ad; tcmd = bus.PCI_CBE; in_fr = 1'b1; first_d = 1'b1;
            if (seen_fr) begin
              total++;
              if (hi_run < 2) begin
                bad++;
                $display("FAIL frame_gap: FRAME high for %0d clocks, required >= 2", hi_run);
              end
            end
            seen_fr = 1'b1;
          end
          if (!bus.PCI_DEVSEL && (tcmd == 4'h2 || tcmd == 4'h8)) begin
            if (first_d) begin wd_ref = pci_ad; first_d = 1'b0; end
            else if (pci_ad !== wd_ref) wd_viol++;
            tmem[{tcmd == 4'h8, taddr[7:2]}] = pci_ad;
            if (tcmd == 4'h8) we_cnt++;
          end
          if (!bus.PCI_DEVSEL && (tcmd == 4'h1 || tcmd == 4'h4) && dut.ad_oe_q) ovl_viol++;
          hi_run = 0;
        end else begin
          in_fr = 1'b0;
          hi_run++;
        end
      end
    end
  end

  // Transaction-level reference: response error, latency, read data.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                       output logic e, output logic [31:0] rd, output int lat);
    logic [32:0] k;
    logic [31:0] v;
    logic        is_rd, is_wr;
    k     = {(op == 4'h4 || op == 4'h8), a};
    is_rd = (op == 4'h1 || op == 4'h4);
    is_wr = (op == 4'h2 || op == 4'h8);
    e     = !(is_rd || is_wr);
    lat   = e ? 1 : (is_rd ? DC + 3 : DC + 2);
    if (is_wr) ref_mem[k] = d;
    if (is_rd) begin
      v = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
      if (op == 4'h1 && a == 32'h4) v = v & 32'h1FF;
      ref_rdata = v;
    end
    rd = ref_rdata;
  endtask

  // Issue one command; returns at the negedge where RSP_VALID is seen.
  // lat = posedges from accept to the edge that samples RSP_VALID high.
  task automatic do_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                        output logic e, output logic [31:0] rd, output int lat);
    int k;
    @(negedge clk);
    bus.CMD_VALID = 1'b1; bus.CMD_OP = op; bus.CMD_ADDR = a; bus.CMD_WDATA = d;
    k = 0;
    while (!bus.CMD_READY && k < 50) begin @(negedge clk); k++; end
    if (!bus.CMD_READY) begin
      total++; bad++;
      $display("FAIL accept_timeout: ready=%b required 1", bus.CMD_READY);
    end
    @(posedge clk);
    @(negedge clk);
    bus.CMD_VALID = 1'b0; bus.CMD_OP = 4'h3; bus.CMD_ADDR = $urandom; bus.CMD_WDATA = $urandom;
    lat = 1;
    while (!bus.RSP_VALID && lat < 60) begin @(negedge clk); lat++; end
    if (!bus.RSP_VALID) begin
      total++; bad++;
      $display("FAIL rsp_timeout: no RSP_VALID within %0d clocks", lat);
    end
    e  = bus.RSP_ERR;
    rd = bus.RSP_RDATA;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({bus.CMD_READY, bus.RSP_VALID, bus.RSP_ERR, bus.BUSY} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctrl: ready/rspv/err/busy=%b required 1000",
               {bus.CMD_READY, bus.RSP_VALID, bus.RSP_ERR, bus.BUSY});
    end
    total++;
    if ({bus.PCI_FRAME, bus.PCI_DEVSEL, bus.PCI_CBE, dut.ad_oe_q} !== 7'b1111110) begin
      bad++;
      $display("FAIL reset_bus: frame/devsel/cbe/ad_oe=%b required 1111110",
               {bus.PCI_FRAME, bus.PCI_DEVSEL, bus.PCI_CBE, dut.ad_oe_q});
    end
    total++;
    if (bus.RSP_RDATA !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h required 00000000", bus.RSP_RDATA);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mod_rw();
    logic e, me; logic [31:0] rd, mrd; int lat, mlat;
    model(4'h2, 32'hC, 32'hDEADBEEF, me, mrd, mlat);
    do_cmd(4'h2, 32'hC, 32'hDEADBEEF, e, rd, lat);
    total++;
    if (e !== 1'b0 || lat != DC + 2) begin
      bad++; $display("FAIL mod_write: err=%b lat=%0d required err=0 lat=%0d", e, lat, DC + 2);
    end
    total++;
    if (bus.CMD_READY !== 1'b0) begin
      bad++; $display("FAIL ready_during_rsp: got %b required 0", bus.CMD_READY);
    end
    @(negedge clk);
    total++;
    if (bus.CMD_READY !== 1'b1 || bus.RSP_VALID !== 1'b0) begin
      bad++; $display("FAIL ready_after_rsp: ready=%b rspv=%b required 1 0", bus.CMD_READY, bus.RSP_VALID);
    end
    model(4'h1, 32'hC, 32'h0, me, mrd, mlat);
    do_cmd(4'h1, 32'hC, 32'h0, e, rd, lat);
    total++;
    if (e !== 1'b0 || rd !== 32'hDEADBEEF || lat != DC + 3) begin
      bad++; $display("FAIL mod_read: err=%b data=%h lat=%0d required 0 deadbeef %0d", e, rd, lat, DC + 3);
    end
  endtask

  task automatic test_gpio_loopback();
    logic e, me; logic [31:0] rd, mrd; int lat, mlat;
    model(4'h2, 32'h0, 32'h1FF, me, mrd, mlat); do_cmd(4'h2, 32'h0, 32'h1FF, e, rd, lat);
    model(4'h2, 32'h4, 32'h0A5, me, mrd, mlat); do_cmd(4'h2, 32'h4, 32'h0A5, e, rd, lat);
    model(4'h1, 32'h4, 32'h0, me, mrd, mlat);   do_cmd(4'h1, 32'h4, 32'h0, e, rd, lat);
    total++;
    if (rd !== 32'h0000_00A5 || e !== 1'b0) begin
      bad++; $display("FAIL gpio_loopback: data=%h err=%b required 000000a5 0", rd, e);
    end
  endtask

  task automatic test_dev_write();
    logic e, me; logic [31:0] rd, mrd; int lat, mlat, w0;
    w0 = we_cnt;
    model(4'h8, 32'h100, 32'h12345678, me, mrd, mlat);
    do_cmd(4'h8, 32'h100, 32'h12345678, e, rd, lat);
    total++;
    if (we_cnt - w0 != DC) begin
      bad++; $display("FAIL dev_we_count: got %0d required %0d", we_cnt - w0, DC);
    end
    total++;
    if (taddr !== 32'h100 || tmem[7'h40] !== 32'h12345678) begin
      bad++; $display("FAIL dev_addr_data: addr=%h data=%h required 00000100 12345678", taddr, tmem[7'h40]);
    end
    total++;
    if ({bus.PCI_FRAME, bus.PCI_DEVSEL, dut.ad_oe_q} !== 3'b110) begin
      bad++; $display("FAIL recover_bus: frame/devsel/ad_oe=%b required 110",
                      {bus.PCI_FRAME, bus.PCI_DEVSEL, dut.ad_oe_q});
    end
    total++;
    if (e !== me || lat != mlat) begin
      bad++; $display("FAIL dev_write_rsp: err=%b lat=%0d required %b %0d", e, lat, me, mlat);
    end
  endtask

  task automatic test_illegal_op();
    logic e, me; logic [31:0] rd, mrd; int lat, mlat, f0;
    f0 = frame_low_cnt;
    model(4'h3, 32'h8, 32'h55, me, mrd, mlat);
    do_cmd(4'h3, 32'h8, 32'h55, e, rd, lat);
    total++;
    if (e !== 1'b1 || lat != 1 || rd !== mrd) begin
      bad++; $display("FAIL illegal_op: err=%b lat=%0d data=%h required 1 1 %h", e, lat, rd, mrd);
    end
    total++;
    if (frame_low_cnt != f0) begin
      bad++; $display("FAIL illegal_frame: FRAME low %0d clocks, required 0", frame_low_cnt - f0);
    end
  endtask

  task automatic test_reset_mid();
    logic e, me; logic [31:0] rd, mrd; int lat, mlat, r0, k;
    @(negedge clk);
    bus.CMD_VALID = 1'b1; bus.CMD_OP = 4'h1; bus.CMD_ADDR = 32'hC;
    k = 0;
    while (!bus.CMD_READY && k < 50) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk); bus.CMD_VALID = 1'b0;   // address phase
    @(negedge clk);                         // turnaround
    total++;
    if ({bus.PCI_FRAME, bus.PCI_DEVSEL, dut.ad_oe_q} !== 3'b010) begin
      bad++; $display("FAIL turnaround: frame/devsel/ad_oe=%b required 010",
                      {bus.PCI_FRAME, bus.PCI_DEVSEL, dut.ad_oe_q});
    end
    r0 = rsp_cnt;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.PCI_FRAME, bus.PCI_DEVSEL, dut.ad_oe_q, bus.BUSY} !== 4'b1100) begin
      bad++; $display("FAIL reset_abort: frame/devsel/ad_oe/busy=%b required 1100",
                      {bus.PCI_FRAME, bus.PCI_DEVSEL, dut.ad_oe_q, bus.BUSY});
    end
    repeat (3) @(negedge clk);
    total++;
    if (rsp_cnt != r0 || bus.RSP_VALID !== 1'b0) begin
      bad++; $display("FAIL reset_no_rsp: pulses=%0d required 0", rsp_cnt - r0);
    end
    rst_n = 1'b1;
    ref_rdata = '0;
    model(4'h1, 32'hC, 32'h0, me, mrd, mlat);
    do_cmd(4'h1, 32'hC, 32'h0, e, rd, lat);
    total++;
    if (e !== 1'b0 || rd !== 32'hDEADBEEF || lat != mlat) begin
      bad++; $display("FAIL post_reset_read: err=%b data=%h lat=%0d required 0 deadbeef %0d", e, rd, lat, mlat);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3] = '{4'h8, 4'h8, 4'h2};
    logic [31:0] adr [3] = '{32'h104, 32'h108, 32'h8};
    logic [31:0] dat [3];
    logic e, me; logic [31:0] rd, mrd; int lat, mlat, r0, k;
    for (int i = 0; i < 3; i++) dat[i] = $urandom;
    r0 = rsp_cnt;
    @(negedge clk);
    bus.CMD_VALID = 1'b1; bus.CMD_OP = ops[0]; bus.CMD_ADDR = adr[0]; bus.CMD_WDATA = dat[0];
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (!bus.CMD_READY && k < 50) begin @(negedge clk); k++; end
      @(posedge clk);
      model(ops[i], adr[i], dat[i], me, mrd, mlat);
      @(negedge clk);
      if (i < 2) begin
        bus.CMD_OP = ops[i+1]; bus.CMD_ADDR = adr[i+1]; bus.CMD_WDATA = dat[i+1];
      end else bus.CMD_VALID = 1'b0;
    end
    k = 0;
    while (rsp_cnt - r0 < 3 && k < 100) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    total++;
    if (rsp_cnt - r0 != 3) begin
      bad++; $display("FAIL b2b_pulses: got %0d required 3", rsp_cnt - r0);
    end
    model(4'h4, 32'h108, 32'h0, me, mrd, mlat);
    do_cmd(4'h4, 32'h108, 32'h0, e, rd, lat);
    total++;
    if (rd !== mrd || e !== 1'b0) begin
      bad++; $display("FAIL b2b_readback: data=%h required %h", rd, mrd);
    end
  endtask

  task automatic test_random();
    logic [3:0] optab [12] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h0, 4'h5, 4'hF};
    logic [3:0] op; logic [31:0] a, d;
    logic e, me; logic [31:0] rd, mrd; int lat, mlat;
    for (int n = 0; n < 24; n++) begin
      op = optab[$urandom_range(0, 11)];
      if (op == 4'h4 || op == 4'h8) a = 32'h100 + 32'(4 * $urandom_range(0, 2));
      else a = 32'(4 * $urandom_range(0, 3));
      d = $urandom;
      model(op, a, d, me, mrd, mlat);
      do_cmd(op, a, d, e, rd, lat);
      total++;
      if (e !== me || rd !== mrd || lat != mlat) begin
        bad++;
        $display("FAIL random[%0d] op=%h addr=%h: err=%b data=%h lat=%0d required %b %h %0d",
                 n, op, a, e, rd, lat, me, mrd, mlat);
      end
    end
  endtask

  task automatic test_bus_rules();
    total++;
    if (wd_viol != 0) begin
      bad++; $display("FAIL write_data_stable: %0d changes required 0", wd_viol);
    end
    total++;
    if (ovl_viol != 0) begin
      bad++; $display("FAIL read_ad_overlap: %0d clocks required 0", ovl_viol);
    end
  endtask

  initial begin
    bus.CMD_VALID = 1'b0; bus.CMD_OP = 4'h0; bus.CMD_ADDR = '0; bus.CMD_WDATA = '0;
    test_reset();
    test_mod_rw();
    test_gpio_loopback();
    test_dev_write();
    test_illegal_op();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_bus_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
